mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//   Shares one unified memory port between the core's instruction-fetch requester
//   (IF) and its load/store requester (D). Arbitrates, holds the grant until the
//   memory completes, and returns registered read data plus a one-cycle ready pulse.
//   The core stalls on !ready. Sits between the core and the unified instruction/data RAM.
// PARAMETERS
//   AW           32  address width, bits
//   DW           32  data width, bits; byte enables are DW/8
//   D_BURST_MAX  4   consecutive D grants allowed while IF is waiting; then IF wins
// PORTS
//   clk        in   1      clock, rising edge
//   reset      in   1      asynchronous, active-high
//   if_req     in   1      fetch request; held with if_addr until if_ready
//   if_addr    in   AW     fetch address, word aligned
//   if_rdata   out  DW     fetched word, valid in the if_ready cycle and held after it
//   if_ready   out  1      one-cycle completion pulse for IF
//   d_req      in   1      load/store request; held with its qualifiers until d_ready
//   d_we       in   1      1 = store, 0 = load
//   d_addr     in   AW     data address
//   d_wdata    in   DW     store data
//   d_be       in   DW/8   byte enables; loads may pass all-ones
//   d_rdata    out  DW     load data, valid in the d_ready cycle and held after it
//   d_ready    out  1      one-cycle completion pulse for D
//   mem_valid  out  1      memory request strobe, registered
//   mem_we     out  1      write strobe; 0 for every IF grant
//   mem_addr   out  AW     registered address
//   mem_wdata  out  DW     registered write data
//   mem_be     out  DW/8   registered byte enables; all-ones for IF
//   mem_rdata  in   DW     memory read data, sampled only when mem_ready=1
//   mem_ready  in   1      memory completion; may assert in the first mem_valid cycle
//   busy       out  1      1 in any state other than IDLE
// BEHAVIOUR
//   - Reset: state=IDLE; all outputs 0, including if_rdata, d_rdata and burst count.
//     Reset mid-transaction aborts it. mem_valid drops asynchronously. No ready is issued.
//   - FSM, encoded in the package enum:
//       IDLE  -> GNT_D  when d_req and (!if_req or cnt<D_BURST_MAX)
//       IDLE  -> GNT_IF when if_req and (!d_req or cnt==D_BURST_MAX)
//       GNT_x -> RSP_x  on mem_ready; otherwise stay (unbounded wait, no timeout)
//       RSP_x -> IDLE   unconditionally
//   - On the IDLE->GNT transition, register mem_addr/we/wdata/be from the winner.
//     mem_valid=1 exactly in GNT states.
//   - In GNT_x with mem_ready: capture mem_rdata into x_rdata, including on stores.
//     The rdata registers change only at this capture.
//   - x_ready=1 exactly in RSP_x. No grant is made in RSP.
//     A requester still holding req is re-arbitrated in the next IDLE cycle.
//   - Latency: req seen in IDLE cycle 0, mem_valid in cycle 1.
//     With mem_ready in cycle N>=1, ready is in cycle N+1 and IDLE in cycle N+2.
//     Peak rate is one transaction per 3 cycles.
//   - Priority: D beats IF. The D belongs to the executing instruction; IF fetches the next.
//   - Starvation guard: cnt (width clog2(D_BURST_MAX+1)) increments on each D grant
//     made while if_req=1. It clears on any IF grant and saturates at D_BURST_MAX.
//     It is not cleared by a D grant made with if_req=0.
//   - Requester drops req or changes qualifiers during GNT: protocol violation.
//     The registered request completes unchanged. Flagged by a bench assertion only.
//   - mem_ready outside GNT states is ignored.
// STRUCTURE
//   - Shared package: arb_state_e enum (IDLE, GNT_IF, GNT_D, RSP_IF, RSP_D),
//     requester id constants REQ_IF=0 and REQ_D=1, and a default D_BURST_MAX constant.
//   - Single flat module, no sub-module. The only datapath is the request-capture and
//     rdata registers, all in this module.
// TESTING
//   - Reset values: hold reset 3 cycles with both reqs high.
//     -> all outputs 0; first mem_valid comes 1 cycle after release, and it is D.
//   - Lone IF fetch: if_addr=0x100; memory returns 0x00500093 with mem_ready in the
//     first valid cycle.
//     -> mem_we=0, mem_be=4'hF; if_ready at cycle 2 with if_rdata=0x00500093; busy 0 at cycle 3.
//   - Store with waits: d_we=1, d_addr=0x2004, d_wdata=0xDEADBEEF, d_be=4'b0011,
//     mem_ready after 3 wait cycles.
//     -> mem_* stable for 4 valid cycles; d_ready exactly 1 cycle.
//   - Collision: if_req and d_req rise together.
//     -> D is served first (d_ready), then IF (if_ready 3 cycles later).
//   - Starvation: if_req held, d_req re-asserted continuously, D_BURST_MAX=4.
//     -> exactly 4 D grants, then 1 IF grant, then D resumes; cnt reads 0 after the IF grant.
//   - Reset mid-grant: assert reset in GNT_D before mem_ready.
//     -> mem_valid falls in the same cycle; no d_ready; d_rdata stays 0.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the unified memory bus arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GNT_IF = 3'd1,
    GNT_D  = 3'd2,
    RSP_IF = 3'd3,
    RSP_D  = 3'd4
  } arb_state_e;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  localparam int D_BURST_MAX_DEFAULT = 4;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Two-requester (fetch / load-store) arbiter for a single unified memory port,
// with D priority, a starvation guard for IF, and registered read data.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int D_BURST_MAX = D_BURST_MAX_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_ready,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic [DW-1:0]   d_rdata,
  output logic            d_ready,
  output logic            mem_valid,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ready,
  output logic            busy
);

  localparam int BW = DW / 8;
  localparam int CW = $clog2(D_BURST_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(D_BURST_MAX);

  arb_state_e    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          grant;
  logic          grant_id;

  logic          mem_we_reg;
  logic [AW-1:0] mem_addr_reg;
  logic [DW-1:0] mem_wdata_reg;
  logic [BW-1:0] mem_be_reg;
  logic [DW-1:0] if_rdata_reg;
  logic [DW-1:0] d_rdata_reg;

  // D only wins while the guard has headroom, so the increment never overflows.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    grant      = 1'b0;
    grant_id   = REQ_IF;
    case (state_reg)
      IDLE: begin
        if (d_req && (!if_req || (cnt_reg < CNT_MAX))) begin
          grant      = 1'b1;
          grant_id   = REQ_D;
          state_next = GNT_D;
          if (if_req) cnt_next = cnt_reg + 1'b1;
        end else if (if_req) begin
          grant      = 1'b1;
          grant_id   = REQ_IF;
          state_next = GNT_IF;
          cnt_next   = '0;
        end
      end
      GNT_IF:  if (mem_ready) state_next = RSP_IF;
      GNT_D:   if (mem_ready) state_next = RSP_D;
      RSP_IF:  state_next = IDLE;
      RSP_D:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_be_reg    <= '0;
      if_rdata_reg  <= '0;
      d_rdata_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (grant) begin
        if (grant_id == REQ_D) begin
          mem_we_reg    <= d_we;
          mem_addr_reg  <= d_addr;
          mem_wdata_reg <= d_wdata;
          mem_be_reg    <= d_be;
        end else begin
          mem_we_reg    <= 1'b0;
          mem_addr_reg  <= if_addr;
          mem_wdata_reg <= '0;
          mem_be_reg    <= '1;
        end
      end
      // Stores capture too, so d_rdata always reflects the last completion.
      if ((state_reg == GNT_IF) && mem_ready) if_rdata_reg <= mem_rdata;
      if ((state_reg == GNT_D) && mem_ready)  d_rdata_reg  <= mem_rdata;
    end
  end

  assign mem_valid = (state_reg == GNT_IF) || (state_reg == GNT_D);
  assign if_ready  = (state_reg == RSP_IF);
  assign d_ready   = (state_reg == RSP_D);
  assign busy      = (state_reg != IDLE);
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_be    = mem_be_reg;
  assign if_rdata  = if_rdata_reg;
  assign d_rdata   = d_rdata_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_mem_bus_arbiter;

  localparam int BURST = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  mem_bus_arbiter #(.AW(32), .DW(32), .D_BURST_MAX(BURST)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding memory transaction at a time.
  bit        m_active = 1'b0;
  bit        m_done   = 1'b0;
  bit        m_owner_d = 1'b0;
  bit        m_we     = 1'b0;
  bit [31:0] m_addr   = '0;
  bit [31:0] m_wdata  = '0;
  bit [3:0]  m_be     = '0;
  bit [31:0] m_if_rdata = '0;
  bit [31:0] m_d_rdata  = '0;
  int        m_streak = 0;

  always @(negedge clk) begin
    if (reset) begin
      m_active = 1'b0; m_done = 1'b0; m_owner_d = 1'b0;
      m_we = 1'b0; m_addr = '0; m_wdata = '0; m_be = '0;
      m_if_rdata = '0; m_d_rdata = '0; m_streak = 0;
    end
    check("m_valid", 32'(mem_valid), 32'(m_active && !m_done));
    check("m_if_ready", 32'(if_ready), 32'(m_active && m_done && !m_owner_d));
    check("m_d_ready", 32'(d_ready), 32'(m_active && m_done && m_owner_d));
    check("m_busy", 32'(busy), 32'(m_active));
    check("m_if_rdata", if_rdata, m_if_rdata);
    check("m_d_rdata", d_rdata, m_d_rdata);
    if (m_active && !m_done) begin
      check("m_we", 32'(mem_we), 32'(m_we));
      check("m_addr", mem_addr, m_addr);
      check("m_be", 32'(mem_be), 32'(m_be));
      if (m_we) check("m_wdata", mem_wdata, m_wdata);
    end
    if (!reset) begin
      if (m_active && !m_done) begin
        if (m_owner_d)
          assert (d_req && d_we == m_we && d_addr == m_addr && d_be == m_be &&
                  (!m_we || d_wdata == m_wdata))
            else $error("protocol: D request changed while granted");
        else
          assert (if_req && if_addr == m_addr)
            else $error("protocol: IF request changed while granted");
      end
      if (!m_active) begin
        if (d_req && (!if_req || m_streak < BURST)) begin
          m_active = 1'b1; m_done = 1'b0; m_owner_d = 1'b1;
          m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; m_be = d_be;
          if (if_req && m_streak < BURST) m_streak++;
        end else if (if_req) begin
          m_active = 1'b1; m_done = 1'b0; m_owner_d = 1'b0;
          m_we = 1'b0; m_addr = if_addr; m_wdata = '0; m_be = 4'hF;
          m_streak = 0;
        end
      end else if (!m_done) begin
        if (mem_ready) begin
          m_done = 1'b1;
          if (m_owner_d) m_d_rdata = mem_rdata;
          else           m_if_rdata = mem_rdata;
        end
      end else begin
        m_active = 1'b0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    int        g;
    logic [10:0] owners;

    // Reset with both requests high
    reset = 1'b1; if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_wdata = '0; d_be = 4'hF;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (3) begin
      mid();
      check("rst_valid", 32'(mem_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
    end
    check("rst_addr", mem_addr, 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_be", 32'(mem_be), 32'd0);
    check("rst_if_ready", 32'(if_ready), 32'd0);
    check("rst_d_ready", 32'(d_ready), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    cyc(); reset = 1'b0;
    mid(); check("rel_valid0", 32'(mem_valid), 32'd0);
    cyc(); mem_ready = 1'b1; mem_rdata = 32'hA5A5_0001;
    mid(); check("first_valid", 32'(mem_valid), 32'd1);
    check("first_is_d", mem_addr, 32'h80);
    cyc(); mem_ready = 1'b0; d_req = 1'b0; if_req = 1'b0;
    mid(); check("first_d_ready", 32'(d_ready), 32'd1);
    check("first_d_rdata", d_rdata, 32'hA5A5_0001);
    cyc(); mid(); check("first_idle", 32'(busy), 32'd0);

    // Lone IF fetch, memory ready in first valid cycle
    cyc(); if_req = 1'b1; if_addr = 32'h100;
    mid(); check("if_c0_busy", 32'(busy), 32'd0);
    cyc(); mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
    mid(); check("if_c1_valid", 32'(mem_valid), 32'd1);
    check("if_c1_we", 32'(mem_we), 32'd0);
    check("if_c1_be", 32'(mem_be), 32'hF);
    check("if_c1_addr", mem_addr, 32'h100);
    cyc(); mem_ready = 1'b0; if_req = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    mid(); check("if_c2_ready", 32'(if_ready), 32'd1);
    check("if_c2_rdata", if_rdata, 32'h0050_0093);
    cyc(); mid(); check("if_c3_busy", 32'(busy), 32'd0);
    check("if_c3_ready", 32'(if_ready), 32'd0);
    check("if_c3_hold", if_rdata, 32'h0050_0093);

    // Store with three wait cycles
    cyc(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
    for (int k = 1; k <= 4; k++) begin
      cyc(); mem_ready = (k == 4); mem_rdata = (k == 4) ? 32'h1234_5678 : 32'h0BAD_0BAD;
      mid();
      check("st_valid", 32'(mem_valid), 32'd1);
      check("st_we", 32'(mem_we), 32'd1);
      check("st_addr", mem_addr, 32'h2004);
      check("st_wdata", mem_wdata, 32'hDEAD_BEEF);
      check("st_be", 32'(mem_be), 32'h3);
      check("st_no_ready", 32'(d_ready), 32'd0);
    end
    cyc(); mem_ready = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = 4'hF;
    mid(); check("st_ready", 32'(d_ready), 32'd1);
    check("st_rdata", d_rdata, 32'h1234_5678);
    cyc(); mid(); check("st_ready_1cyc", 32'(d_ready), 32'd0);
    check("st_idle", 32'(busy), 32'd0);

    // Collision: D first, IF three cycles later
    cyc(); if_req = 1'b1; if_addr = 32'h200; d_req = 1'b1; d_addr = 32'h3000;
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_0001;
    cyc(); mid(); check("col_d_first", mem_addr, 32'h3000);
    cyc(); d_req = 1'b0;
    mid(); check("col_d_ready", 32'(d_ready), 32'd1);
    check("col_d_rdata", d_rdata, 32'hCAFE_0001);
    check("col_if_wait", 32'(if_ready), 32'd0);
    cyc(); mid(); check("col_if_wait2", 32'(if_ready), 32'd0);
    cyc(); mem_rdata = 32'hCAFE_0002;
    mid(); check("col_if_addr", mem_addr, 32'h200);
    cyc(); if_req = 1'b0;
    mid(); check("col_if_ready", 32'(if_ready), 32'd1);
    check("col_if_rdata", if_rdata, 32'hCAFE_0002);
    cyc(); mid(); check("col_idle", 32'(busy), 32'd0);

    // Starvation guard: both held, memory always ready
    cyc(); if_req = 1'b1; if_addr = 32'h300; d_req = 1'b1; d_addr = 32'h4000;
    g = 0; owners = '0;
    for (int c = 0; c < 33; c++) begin
      mid();
      if (mem_valid && g < 11) begin
        owners[g] = (mem_addr == 32'h300);
        g++;
      end
      cyc();
    end
    if_req = 1'b0; d_req = 1'b0;
    check("starve_grants", 32'(g), 32'd11);
    check("starve_order", 32'(owners), 32'(11'b010_0001_0000));

    // Reset during GNT_D before mem_ready
    cyc(); d_req = 1'b1; d_addr = 32'h44; d_we = 1'b0; mem_ready = 1'b0;
    cyc(); mid(); check("rmid_valid", 32'(mem_valid), 32'd1);
    cyc(); reset = 1'b1;
    #1; check("rmid_drop", 32'(mem_valid), 32'd0);
    mid(); check("rmid_rdata", d_rdata, 32'd0);
    check("rmid_no_ready", 32'(d_ready), 32'd0);
    cyc(); d_req = 1'b0;
    cyc(); reset = 1'b0;
    repeat (4) begin
      mid(); check("rmid_after", 32'(d_ready), 32'd0);
      check("rmid_rdata0", d_rdata, 32'd0);
    end

    // Randomized traffic; requesters follow the hold-until-ready protocol
    for (int n = 0; n < 4000; n++) begin
      cyc();
      if (reset) reset = 1'b0;
      else if ($urandom_range(399, 0) == 0) reset = 1'b1;
      if (if_req) begin
        if (m_active && m_done && !m_owner_d) begin
          if_req = ($urandom_range(1, 0) == 1);
          if_addr = $urandom() & 32'hFFFF_FFFC;
        end
      end else if ($urandom_range(9, 0) < 4) begin
        if_req = 1'b1;
        if_addr = $urandom() & 32'hFFFF_FFFC;
      end
      if (d_req) begin
        if (m_active && m_done && m_owner_d) begin
          d_req = ($urandom_range(1, 0) == 1);
          d_we = 1'($urandom_range(1, 0));
          d_addr = $urandom();
          d_wdata = $urandom();
          d_be = d_we ? 4'($urandom_range(15, 1)) : 4'hF;
        end
      end else if ($urandom_range(9, 0) < 5) begin
        d_req = 1'b1;
        d_we = 1'($urandom_range(1, 0));
        d_addr = $urandom();
        d_wdata = $urandom();
        d_be = d_we ? 4'($urandom_range(15, 1)) : 4'hF;
      end
      mem_ready = ($urandom_range(2, 0) != 0);
      mem_rdata = $urandom();
    end

    cyc(); reset = 1'b0; if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b1;
    repeat (4) mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
